// File: rtl/sce_imem_pkg.sv
// -----------------------------------------------------------------------------
// sce_imem_pkg
// Shared definitions for the SCE instruction-memory controller:
//   - default widths for the fetch command, instruction word and SRAM address
//   - imem_rsp_t : one response FIFO entry {err, data}
//   - legality helpers for the SRAM latency and response FIFO depth
// -----------------------------------------------------------------------------
package sce_imem_pkg;

  localparam int IMEM_CMDW    = 32;  // REQ_INFO width (zero-extended word address)
  localparam int IMEM_DW      = 32;  // instruction word width
  localparam int IMEM_MAW     = 10;  // SRAM word-address width
  localparam int MEM_LAT_MIN  = 1;
  localparam int MEM_LAT_MAX  = 2;

  typedef struct packed {
    logic                err;
    logic [IMEM_DW-1:0]  data;
  } imem_rsp_t;

  function automatic bit mem_lat_legal(input int lat);
    return (lat >= MEM_LAT_MIN) && (lat <= MEM_LAT_MAX);
  endfunction

  // The FIFO must hold every read that can be in flight plus one entry.
  function automatic bit rsp_depth_legal(input int depth, input int lat);
    return depth >= (lat + 1);
  endfunction

endpackage

// File: rtl/sce_imem_if.sv
// -----------------------------------------------------------------------------
// sce_imem_if
// Fetcher <-> instruction-memory-controller bus.
//   REQ_VLD/REQ_INFO/REQ_ACK : fetch request, transfer on REQ_VLD & REQ_ACK
//   RSP_VLD/RSP_INFO/RSP_ERR/RSP_ACK : in-order response, pop on RSP_VLD & RSP_ACK
// Modports:
//   master : the fetcher (drives requests, consumes responses)
//   slave  : the controller
// -----------------------------------------------------------------------------
interface sce_imem_if
  import sce_imem_pkg::*;
#(
  parameter int CMDW = IMEM_CMDW,
  parameter int DW   = IMEM_DW
);

  logic            REQ_VLD;
  logic [CMDW-1:0] REQ_INFO;
  logic            REQ_ACK;
  logic            RSP_VLD;
  logic [DW-1:0]   RSP_INFO;
  logic            RSP_ERR;
  logic            RSP_ACK;

  modport master (
    output REQ_VLD, REQ_INFO, RSP_ACK,
    input  REQ_ACK, RSP_VLD, RSP_INFO, RSP_ERR
  );

  modport slave (
    input  REQ_VLD, REQ_INFO, RSP_ACK,
    output REQ_ACK, RSP_VLD, RSP_INFO, RSP_ERR
  );

endinterface

// File: rtl/sce_sync_fifo.sv
// -----------------------------------------------------------------------------
// sce_sync_fifo
// Single-clock FIFO with any DEPTH (not restricted to powers of two).
// Ports:
//   clk_i, rst_i      : clock, synchronous active-high reset
//   push_i, wdata_i   : write strobe and data
//   pop_i             : remove head entry (ignored when empty)
//   rdata_o           : head entry (combinational read)
//   full_o, empty_o   : status
//   count_o           : number of stored entries
// Push and pop in the same cycle leave the count unchanged; a push while full
// is accepted only when a pop frees the slot in that same cycle.
// -----------------------------------------------------------------------------
module sce_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNTW-1:0]  count_o
);

  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTRW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0]  count_q;
  logic             do_push, do_pop;

  // Explicit compare-and-clear so a non power-of-two depth wraps correctly.
  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    return (p == PTRW'(DEPTH - 1)) ? '0 : p + PTRW'(1);
  endfunction

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    full_o  = (count_q == CNTW'(DEPTH));
    empty_o = (count_q == '0);
    do_pop  = pop_i & ~empty_o;
    do_push = push_i & (~full_o | do_pop);
    rdata_o = mem_q[rd_ptr_q];
    count_o = count_q;
  end

  // NOTE: the storage array has no reset; only pointers and count define
  // which entries are live, and leaving it unreset lets it map onto RAM.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNTW'(1);
        2'b01:   count_q <= count_q - CNTW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/sce_imem_ctrl.sv
// -----------------------------------------------------------------------------
// sce_imem_ctrl
// Instruction-memory controller in front of the SCE fetcher. Fetch requests
// (word addresses) are served from a synchronous single-port SRAM and
// returned strictly in request order through a small response FIFO.
// Ports:
//   CLK, RST   : clock, synchronous active-high reset
//   fetch      : sce_imem_if slave (request + response handshakes)
//   MEM_CE     : SRAM read enable (combinational from the accepted request)
//   MEM_ADDR   : SRAM word address, 0 whenever MEM_CE is low
//   MEM_RDATA  : SRAM read data, valid MEM_LAT cycles after the MEM_CE edge
// Flow control is credit based: a request is only acknowledged while the
// reads in flight plus the stored responses leave a free FIFO slot, so an
// SRAM result always has somewhere to land. Addresses with any bit set above
// MAW skip the SRAM and produce an error response in their ordered slot.
// -----------------------------------------------------------------------------
module sce_imem_ctrl
  import sce_imem_pkg::*;
#(
  parameter int CMDW      = IMEM_CMDW,
  parameter int DW        = IMEM_DW,
  parameter int MAW       = IMEM_MAW,
  parameter int MEM_LAT   = 1,
  parameter int RSP_DEPTH = 4
) (
  input  logic           CLK,
  input  logic           RST,
  sce_imem_if.slave      fetch,
  output logic           MEM_CE,
  output logic [MAW-1:0] MEM_ADDR,
  input  logic [DW-1:0]  MEM_RDATA
);

  localparam int              CNTW      = $clog2(RSP_DEPTH + 1);
  localparam logic [CNTW:0]   DEPTH_LIM = (CNTW + 1)'(RSP_DEPTH);

  logic                req_ack, accept, in_range;
  logic [CNTW-1:0]     inflight_q, inflight_d;
  logic [MEM_LAT-1:0]  pipe_vld_q, pipe_err_q;
  logic                exit_vld, exit_err;
  logic                rsp_vld, pop;
  logic                fifo_full, fifo_empty;
  logic [CNTW-1:0]     fifo_count;
  imem_rsp_t           push_rsp, head_rsp;

  // ---------------------------------------------------------------------------
  // Request side: credit, range check and SRAM strobe
  // ---------------------------------------------------------------------------
  always_comb begin
    req_ack  = ~RST & (({1'b0, inflight_q} + {1'b0, fifo_count}) < DEPTH_LIM);
    accept   = fetch.REQ_VLD & req_ack;
    in_range = (fetch.REQ_INFO[CMDW-1:MAW] == '0);
    MEM_CE   = accept & in_range;
    MEM_ADDR = MEM_CE ? fetch.REQ_INFO[MAW-1:0] : '0;
  end

  assign fetch.REQ_ACK = req_ack;

  // ---------------------------------------------------------------------------
  // Latency pipeline: one {valid, err} stage per SRAM read cycle, so the
  // stage output lines up with MEM_RDATA for in-range requests.
  // ---------------------------------------------------------------------------
  assign exit_vld = pipe_vld_q[MEM_LAT-1];
  assign exit_err = pipe_err_q[MEM_LAT-1];

  always_comb begin
    case ({accept, exit_vld})
      2'b10:   inflight_d = inflight_q + CNTW'(1);
      2'b01:   inflight_d = inflight_q - CNTW'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pipe_vld_q <= '0;
      pipe_err_q <= '0;
      inflight_q <= '0;
    end else begin
      pipe_vld_q[0] <= accept;
      pipe_err_q[0] <= accept & ~in_range;
      for (int i = 1; i < MEM_LAT; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_err_q[i] <= pipe_err_q[i-1];
      end
      inflight_q <= inflight_d;
    end
  end

  // Error entries carry zero data; the SRAM bus is not driven for them.
  always_comb begin
    push_rsp.err  = exit_err;
    push_rsp.data = exit_err ? '0 : MEM_RDATA;
  end

  // ---------------------------------------------------------------------------
  // Response FIFO
  // ---------------------------------------------------------------------------
  sce_sync_fifo #(
    .WIDTH (DW + 1),
    .DEPTH (RSP_DEPTH),
    .CNTW  (CNTW)
  ) u_rsp_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (exit_vld),
    .wdata_i (push_rsp),
    .pop_i   (pop),
    .rdata_o (head_rsp),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    rsp_vld = ~RST & ~fifo_empty;
    pop     = rsp_vld & fetch.RSP_ACK;
  end

  assign fetch.RSP_VLD  = rsp_vld;
  assign fetch.RSP_INFO = rsp_vld ? head_rsp.data : '0;
  assign fetch.RSP_ERR  = rsp_vld & head_rsp.err;

  // ---------------------------------------------------------------------------
  // Simulation checks
  // ---------------------------------------------------------------------------
  a_lat_legal: assert property (@(posedge CLK) mem_lat_legal(MEM_LAT));
  a_depth_legal: assert property (@(posedge CLK) rsp_depth_legal(RSP_DEPTH, MEM_LAT));
  // The response struct is fixed-width in the package.
  a_dw_match: assert property (@(posedge CLK) DW == IMEM_DW);
  // Credit makes it impossible for a read to return into a full FIFO.
  a_no_overflow: assert property (@(posedge CLK) disable iff (RST)
                                  !(exit_vld && fifo_full && !pop));

endmodule

// File: tb/tb_sce_imem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sce_imem_ctrl
// Two controllers (MEM_LAT = 1 and MEM_LAT = 2) share one stimulus stream.
// Each has its own SRAM model and a scoreboard: every accepted request pushes
// its expected response, computed straight from the memory contents and the
// address range, together with its accept edge. A monitor compares the DUT
// every cycle against the queue: a response is due once both its SRAM latency
// has elapsed and the previous response has been popped, and REQ_ACK must be
// high exactly while fewer than RSP_DEPTH responses are outstanding.
// -----------------------------------------------------------------------------
module tb_sce_imem_ctrl;

  localparam int CMDW      = 32;
  localparam int DW        = 32;
  localparam int MAW       = 10;
  localparam int RSP_DEPTH = 4;

  typedef struct {
    logic          err;
    logic [DW-1:0] data;
    int            acc;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_vld;
  logic [CMDW-1:0] req_info;
  logic            rsp_ack;
  logic [DW-1:0]   mem [0:(1<<MAW)-1];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int LAT = g + 1;

    sce_imem_if #(.CMDW(CMDW), .DW(DW)) bus ();
    logic           mem_ce;
    logic [MAW-1:0] mem_addr;
    logic [DW-1:0]  mem_rdata;
    logic [DW-1:0]  rd_pipe [LAT];

    assign bus.REQ_VLD  = req_vld;
    assign bus.REQ_INFO = req_info;
    assign bus.RSP_ACK  = rsp_ack;

    sce_imem_ctrl #(
      .CMDW(CMDW), .DW(DW), .MAW(MAW), .MEM_LAT(LAT), .RSP_DEPTH(RSP_DEPTH)
    ) dut (
      .CLK       (clk),
      .RST       (rst),
      .fetch     (bus),
      .MEM_CE    (mem_ce),
      .MEM_ADDR  (mem_addr),
      .MEM_RDATA (mem_rdata)
    );

    // SRAM: read data appears LAT edges after the enable edge; junk otherwise.
    always @(posedge clk) begin
      rd_pipe[0] <= mem_ce ? mem[mem_addr] : $urandom;
      for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[LAT-1];

    exp_t            q[$];
    int              edge_n   = 0;
    int              last_pop = 0;
    int              n_acc    = 0;
    bit              last_rst = 1'b1;
    bit              s_rst, s_acc, s_pop;
    logic [CMDW-1:0] s_addr;

    // Monitor: sample and compare mid-cycle, remember the handshakes.
    always @(negedge clk) begin
      int             due;
      logic           exp_ce;
      logic [MAW-1:0] exp_addr;
      due    = 0;
      s_rst  = rst;
      s_acc  = req_vld && bus.REQ_ACK && !rst;
      s_pop  = bus.RSP_VLD && rsp_ack && !rst;
      s_addr = req_info;
      if (rst) begin
        check($sformatf("L%0d rst REQ_ACK", LAT),  bus.REQ_ACK,  0);
        check($sformatf("L%0d rst RSP_VLD", LAT),  bus.RSP_VLD,  0);
        check($sformatf("L%0d rst RSP_INFO", LAT), bus.RSP_INFO, 0);
        check($sformatf("L%0d rst RSP_ERR", LAT),  bus.RSP_ERR,  0);
        check($sformatf("L%0d rst MEM_CE", LAT),   mem_ce,       0);
        check($sformatf("L%0d rst MEM_ADDR", LAT), mem_addr,     0);
      end else begin
        if (last_rst) check($sformatf("L%0d REQ_ACK after reset", LAT), bus.REQ_ACK, 1);
        check($sformatf("L%0d credit REQ_ACK", LAT), bus.REQ_ACK, q.size() < RSP_DEPTH);
        exp_ce   = s_acc && (s_addr[CMDW-1:MAW] == '0);
        exp_addr = exp_ce ? s_addr[MAW-1:0] : '0;
        check($sformatf("L%0d MEM_CE", LAT),   mem_ce,   exp_ce);
        check($sformatf("L%0d MEM_ADDR", LAT), mem_addr, exp_addr);
        if (q.size() != 0) begin
          due = q[0].acc + LAT;
          if (last_pop > due) due = last_pop;
        end
        if (q.size() != 0 && edge_n >= due) begin
          check($sformatf("L%0d RSP_VLD due", LAT), bus.RSP_VLD,  1);
          check($sformatf("L%0d RSP_INFO", LAT),    bus.RSP_INFO, q[0].data);
          check($sformatf("L%0d RSP_ERR", LAT),     bus.RSP_ERR,  q[0].err);
        end else begin
          check($sformatf("L%0d RSP_VLD idle", LAT), bus.RSP_VLD,  0);
          check($sformatf("L%0d RSP_INFO idle", LAT), bus.RSP_INFO, 0);
          check($sformatf("L%0d RSP_ERR idle", LAT), bus.RSP_ERR,  0);
        end
      end
    end

    // Scoreboard update at the edge where the handshakes take effect.
    always @(posedge clk) begin
      exp_t e;
      edge_n++;
      if (s_rst) begin
        q.delete();
        last_rst = 1'b1;
      end else begin
        last_rst = 1'b0;
        if (s_pop && q.size() != 0) begin
          void'(q.pop_front());
          last_pop = edge_n;
        end
        if (s_acc) begin
          e.err  = (s_addr[CMDW-1:MAW] != '0);
          e.data = e.err ? '0 : mem[s_addr[MAW-1:0]];
          e.acc  = edge_n;
          q.push_back(e);
          n_acc++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    req_vld = 1'b0;
    rsp_ack = 1'b1;
    for (int i = 0; i < 60 && (lane[0].q.size() != 0 || lane[1].q.size() != 0); i++) tick();
    check("L1 drained", lane[0].q.size(), 0);
    check("L2 drained", lane[1].q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, b1;
    logic [CMDW-1:0] a;
    for (int i = 0; i < (1 << MAW); i++) mem[i] = $urandom;
    mem[5] = 32'hDEAD_BEEF;

    // 1: reset held three edges with a request pending
    rst = 1'b1; req_vld = 1'b1; req_info = '0; rsp_ack = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // 2: single in-range request, accepted in the first cycle after reset
    req_info = 5; rsp_ack = 1'b1;
    tick();
    req_vld = 1'b0;
    repeat (4) tick();
    drain();

    // 3: responses blocked, eight requests offered back-to-back
    rsp_ack = 1'b0;
    b0 = lane[0].n_acc; b1 = lane[1].n_acc;
    for (int i = 0; i < 8; i++) begin
      req_vld = 1'b1; req_info = i;
      tick();
    end
    req_vld = 1'b0;
    check("L1 accepted while blocked", lane[0].n_acc - b0, RSP_DEPTH);
    check("L2 accepted while blocked", lane[1].n_acc - b1, RSP_DEPTH);
    drain();

    // 4: top of range, first out-of-range address, bottom of range
    rsp_ack = 1'b1;
    req_vld = 1'b1; req_info = 32'h3FF; tick();
    req_info = 32'h400; tick();
    req_info = 32'h000; tick();
    drain();

    // 5: sixteen consecutive requests with responses always consumed
    b0 = lane[0].n_acc; b1 = lane[1].n_acc;
    for (int i = 0; i < 16; i++) begin
      req_vld = 1'b1; req_info = $urandom_range(0, (1 << MAW) - 1);
      tick();
    end
    req_vld = 1'b0;
    check("L1 streaming accepts", lane[0].n_acc - b0, 16);
    check("L2 streaming accepts", lane[1].n_acc - b1, 16);
    drain();

    // 6: full pipeline/FIFO, single-cycle reset, then a fresh request
    rsp_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req_vld = 1'b1; req_info = 100 + i;
      tick();
    end
    rst = 1'b1; req_vld = 1'b1;
    tick();
    rst = 1'b0; req_vld = 1'b0;
    repeat (4) tick();
    req_vld = 1'b1; req_info = 7; rsp_ack = 1'b1;
    tick();
    drain();

    // Random traffic with occasional out-of-range addresses and resets
    for (int c = 0; c < 800; c++) begin
      rst     = ($urandom_range(0, 99) == 0);
      req_vld = ($urandom_range(0, 99) < 70);
      rsp_ack = ($urandom_range(0, 99) < 60);
      if ($urandom_range(0, 9) == 0) begin
        a = $urandom;
        if (a[CMDW-1:MAW] == '0) a[MAW] = 1'b1;
      end else begin
        a = $urandom_range(0, (1 << MAW) - 1);
      end
      req_info = a;
      tick();
    end
    rst = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
